// File: rtl/zmx_rotate_ctrl.sv
// Turns debounced cw/ccw key presses into a one-hot rotate select for the video crossbar.
// Rotation changes are held in PENDING and only applied on a frame boundary (vsync edge) or timeout.
module zmx_rotate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAME_TIMEOUT   = 2000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_cw_n,
  input  logic       key_ccw_n,
  input  logic       vs_in,
  output logic [3:0] key_in_ctl,
  output logic [1:0] rot_idx,
  output logic       switch_pending,
  output logic       switch_done
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TOW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(FRAME_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  // Bit 0 = clockwise key, bit 1 = counter-clockwise key.
  logic [1:0]     key_s1, key_s2, key_db, key_db_q;
  logic [DBW-1:0] db_cnt [2];
  logic           vs_s1, vs_s2, vs_q;

  logic [1:0]     press;
  logic [1:0]     step;
  logic           vs_edge;

  logic [1:0]     state;
  logic [1:0]     target;
  logic [1:0]     carry;
  logic [TOW-1:0] to_cnt;
  logic [1:0]     target_step;
  logic [1:0]     apply_step;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_s1   <= 2'b11;
      key_s2   <= 2'b11;
      key_db   <= 2'b11;
      key_db_q <= 2'b11;
      vs_s1    <= 1'b0;
      vs_s2    <= 1'b0;
      vs_q     <= 1'b0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      key_s1   <= {key_ccw_n, key_cw_n};
      key_s2   <= key_s1;
      key_db_q <= key_db;
      vs_s1    <= vs_in;
      vs_s2    <= vs_s1;
      vs_q     <= vs_s2;
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          key_db[i] <= key_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press = falling edge of the debounced level; simultaneous presses cancel.
  assign press   = key_db_q & ~key_db;
  assign vs_edge = vs_s2 & ~vs_q;

  always_comb begin
    step = 2'd0;
    case (press)
      2'b01:   step = 2'd1;
      2'b10:   step = 2'd3;
      default: step = 2'd0;
    endcase
  end

  assign target_step = target + step;
  assign apply_step  = carry + step;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      target      <= 2'd0;
      carry       <= 2'd0;
      to_cnt      <= '0;
      rot_idx     <= 2'd0;
      key_in_ctl  <= 4'b0001;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step != 2'd0) begin
            target <= rot_idx + step;
            to_cnt <= '0;
            state  <= S_PEND;
          end
        end
        S_PEND: begin
          if (vs_edge || to_cnt == TO_MAX) begin
            state <= S_APPLY;
            carry <= step;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (step != 2'd0) begin
              target <= target_step;
              if (target_step == rot_idx) state <= S_IDLE;
            end
          end
        end
        S_APPLY: begin
          rot_idx     <= target;
          key_in_ctl  <= 4'b0001 << target;
          switch_done <= 1'b1;
          carry       <= 2'd0;
          // A step carried from the apply decision (or arriving now) opens a new request.
          if (apply_step != 2'd0) begin
            target <= target + apply_step;
            to_cnt <= '0;
            state  <= S_PEND;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign switch_pending = (state == S_PEND);

endmodule

// File: tb/tb_zmx_rotate_ctrl.sv
// Directed bench for zmx_rotate_ctrl with a cycle-level reference model and literal spot checks.
module tb_zmx_rotate_ctrl;
  localparam int DB = 8;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_cw_n = 1'b1;
  logic       key_ccw_n = 1'b1;
  logic       vs_in = 1'b0;
  logic [3:0] key_in_ctl;
  logic [1:0] rot_idx;
  logic       switch_pending;
  logic       switch_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  zmx_rotate_ctrl #(.DEBOUNCE_CYCLES(DB), .FRAME_TIMEOUT(TO)) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .key_cw_n(key_cw_n),
    .key_ccw_n(key_ccw_n),
    .vs_in(vs_in),
    .key_in_ctl(key_in_ctl),
    .rot_idx(rot_idx),
    .switch_pending(switch_pending),
    .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  // Reference model: integer rotation arithmetic, run-length debounce, shift-array syncs.
  bit m_started = 0;
  int m_cw_sync [2], m_ccw_sync [2], m_vs_sync [2];
  int m_vs_prev, m_cw_db, m_ccw_db, m_cw_dbp, m_ccw_dbp, m_cw_run, m_ccw_run;
  int m_phase, m_tgt, m_wait, m_carry, m_rot, m_done;

  always @(posedge clk) begin : model
    int ev_cw, ev_ccw, step, vedge, total;
    if (!rst_n) begin
      m_started = 1;
      m_cw_sync = '{1, 1}; m_ccw_sync = '{1, 1}; m_vs_sync = '{0, 0};
      m_vs_prev = 0; m_cw_db = 1; m_ccw_db = 1; m_cw_dbp = 1; m_ccw_dbp = 1;
      m_cw_run = 0; m_ccw_run = 0;
      m_phase = 0; m_tgt = 0; m_wait = 0; m_carry = 0; m_rot = 0; m_done = 0;
    end else begin
      ev_cw  = (m_cw_dbp == 1 && m_cw_db == 0) ? 1 : 0;
      ev_ccw = (m_ccw_dbp == 1 && m_ccw_db == 0) ? 1 : 0;
      step   = (ev_cw - ev_ccw + 4) % 4;
      vedge  = (m_vs_sync[1] == 1 && m_vs_prev == 0) ? 1 : 0;
      m_done = 0;
      if (m_phase == 0) begin
        if (step != 0) begin m_tgt = (m_rot + step) % 4; m_phase = 1; m_wait = 0; end
      end else if (m_phase == 1) begin
        if (vedge == 1 || m_wait == TO - 1) begin
          m_phase = 2; m_carry = step;
        end else begin
          if (step != 0) begin
            m_tgt = (m_tgt + step) % 4;
            if (m_tgt == m_rot) m_phase = 0;
          end
          m_wait++;
        end
      end else begin
        m_rot = m_tgt; m_done = 1;
        total = (m_carry + step) % 4;
        m_carry = 0;
        if (total != 0) begin m_tgt = (m_rot + total) % 4; m_phase = 1; m_wait = 0; end
        else m_phase = 0;
      end
      m_cw_dbp = m_cw_db; m_ccw_dbp = m_ccw_db;
      if (m_cw_sync[1] == m_cw_db) m_cw_run = 0;
      else if (m_cw_run == DB - 1) begin m_cw_db = m_cw_sync[1]; m_cw_run = 0; end
      else m_cw_run++;
      if (m_ccw_sync[1] == m_ccw_db) m_ccw_run = 0;
      else if (m_ccw_run == DB - 1) begin m_ccw_db = m_ccw_sync[1]; m_ccw_run = 0; end
      else m_ccw_run++;
      m_vs_prev = m_vs_sync[1];
      m_cw_sync[1] = m_cw_sync[0];   m_cw_sync[0] = int'(key_cw_n);
      m_ccw_sync[1] = m_ccw_sync[0]; m_ccw_sync[0] = int'(key_ccw_n);
      m_vs_sync[1] = m_vs_sync[0];   m_vs_sync[0] = int'(vs_in);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      if (switch_done === 1'b1) done_cnt++;
      checks++;
      if (rot_idx !== 2'(m_rot)) begin
        errors++; $display("FAIL model_rot_idx t=%0t got %0d exp %0d", $time, rot_idx, m_rot);
      end
      checks++;
      if (key_in_ctl !== 4'(1 << m_rot)) begin
        errors++; $display("FAIL model_key_in_ctl t=%0t got %b exp %b", $time, key_in_ctl, 4'(1 << m_rot));
      end
      checks++;
      if (switch_pending !== (m_phase == 1)) begin
        errors++; $display("FAIL model_pending t=%0t got %b exp %0d", $time, switch_pending, m_phase == 1);
      end
      checks++;
      if (switch_done !== 1'(m_done)) begin
        errors++; $display("FAIL model_done t=%0t got %b exp %0d", $time, switch_done, m_done);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; key_cw_n = 1'b1; key_ccw_n = 1'b1; vs_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic press(input bit cw, input bit ccw, input int lo, input int hi);
    if (cw) key_cw_n = 1'b0;
    if (ccw) key_ccw_n = 1'b0;
    cyc(lo);
    key_cw_n = 1'b1; key_ccw_n = 1'b1;
    cyc(hi);
  endtask

  task automatic vs_pulse;
    vs_in = 1'b1;
    cyc(3);
    vs_in = 1'b0;
    cyc(10);
  endtask

  int base;

  initial begin
    @(negedge clk);
    // reset state and single cw switch on vsync
    do_reset;
    check("reset_key_in_ctl", 32'(key_in_ctl), 32'h1);
    check("reset_rot_idx", 32'(rot_idx), 0);
    check("reset_pending", 32'(switch_pending), 0);
    base = done_cnt;
    press(1, 0, 20, 15);
    check("cw_pending_before_vs", 32'(switch_pending), 1);
    check("cw_key_before_vs", 32'(key_in_ctl), 32'h1);
    vs_pulse;
    check("cw_rot_idx", 32'(rot_idx), 1);
    check("cw_key_in_ctl", 32'(key_in_ctl), 32'h2);
    check("cw_done_count", 32'(done_cnt - base), 1);
    check("cw_pending_after", 32'(switch_pending), 0);

    // bounce shorter than the debounce window
    do_reset;
    press(1, 0, 5, 20);
    check("bounce_pending", 32'(switch_pending), 0);
    check("bounce_key_in_ctl", 32'(key_in_ctl), 32'h1);

    // ccw from 0 with no vsync: timeout apply and wrap to 3
    do_reset;
    base = done_cnt;
    press(0, 1, 20, 0);
    check("timeout_pending_mid", 32'(switch_pending), 1);
    cyc(110);
    check("timeout_rot_idx", 32'(rot_idx), 3);
    check("timeout_key_in_ctl", 32'(key_in_ctl), 32'h8);
    check("timeout_done_count", 32'(done_cnt - base), 1);
    // 3 + cw wraps to 0
    press(1, 0, 12, 12);
    vs_pulse;
    check("wrap_rot_idx", 32'(rot_idx), 0);
    check("wrap_key_in_ctl", 32'(key_in_ctl), 32'h1);

    // three cw then one ccw before vsync: target 2, one switch
    do_reset;
    base = done_cnt;
    press(1, 0, 12, 12);
    press(1, 0, 12, 12);
    press(1, 0, 12, 12);
    press(0, 1, 12, 0);
    check("multi_rot_before", 32'(rot_idx), 0);
    vs_pulse;
    check("multi_rot_idx", 32'(rot_idx), 2);
    check("multi_key_in_ctl", 32'(key_in_ctl), 32'h4);
    check("multi_done_count", 32'(done_cnt - base), 1);

    // cw then ccw: request cancelled
    do_reset;
    base = done_cnt;
    press(1, 0, 12, 12);
    press(0, 1, 12, 12);
    check("cancel_pending", 32'(switch_pending), 0);
    vs_pulse;
    check("cancel_done_count", 32'(done_cnt - base), 0);
    check("cancel_key_in_ctl", 32'(key_in_ctl), 32'h1);

    // reset while pending discards the request
    do_reset;
    press(1, 0, 12, 12);
    press(1, 0, 12, 12);
    check("rst_mid_pending_before", 32'(switch_pending), 1);
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_key_in_ctl", 32'(key_in_ctl), 32'h1);
    check("rst_mid_pending", 32'(switch_pending), 0);
    rst_n = 1'b1;
    base = done_cnt;
    cyc(2);
    vs_pulse;
    check("rst_mid_done_count", 32'(done_cnt - base), 0);
    check("rst_mid_rot_idx", 32'(rot_idx), 0);

    // both keys together: no step
    do_reset;
    base = done_cnt;
    press(1, 1, 20, 20);
    check("both_pending", 32'(switch_pending), 0);
    vs_pulse;
    check("both_done_count", 32'(done_cnt - base), 0);
    check("both_key_in_ctl", 32'(key_in_ctl), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zmx_rotate_ctrl.md
Name: zmx_rotate_ctrl

Overview:
- Generates the one-hot `key_in_ctl[3:0]` word consumed by the four-channel video rotate crossbar.
- Two user keys (clockwise / counter-clockwise) are synchronised, debounced and edge-detected, then accumulated into a target rotation.
- The new rotation is applied only at an output-frame boundary, taken from the vsync rising edge. A timeout guarantees progress when vsync is absent.
- Sits between the board key inputs and the rotate crossbar, in the system clock domain.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz). Counter width derived internally.
- FRAME_TIMEOUT, 2000000, maximum cycles a request may wait in PENDING before being applied without a vsync edge. Counter width derived internally.

Ports:
- sys_clk  in  1  system clock; all logic rising-edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- key_cw_n  in  1  raw clockwise key, asynchronous, low = pressed.
- key_ccw_n  in  1  raw counter-clockwise key, asynchronous, low = pressed.
- vs_in  in  1  output-frame vsync level from another clock domain, active-high.
- key_in_ctl  out  4  one-hot rotation select, equal to 1 << rot_idx.
- rot_idx  out  2  current applied rotation, 0..3.
- switch_pending  out  1  high while a request waits for a frame boundary.
- switch_done  out  1  one-cycle pulse in the cycle the new rotation first appears on the outputs.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - Outputs: rot_idx=0, key_in_ctl=4'b0001, switch_pending=0, switch_done=0.
  - Internal: synchronisers preset to idle levels (keys 1, vs 0), debounced levels 1, counters 0, state IDLE, target=0.
  - Reset mid-operation discards any pending request.
- Synchronisation: each of key_cw_n, key_ccw_n and vs_in passes through a 2-FF synchroniser.
- Debounce, per key:
  - The counter increments while the synced level differs from the debounced level.
  - It clears whenever the levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced level.
- Press event: a one-cycle pulse on the falling edge of a debounced level. Release produces no event.
- Step decode:
  - cw event alone: +1.
  - ccw event alone: -1 (i.e. +3 mod 4).
  - Both in the same cycle: no step.
- Vsync edge: synced vs = 1 and previous synced vs = 0.
- State machine:
  - IDLE:
    - On a step: target = rot_idx + step (mod 4), go to PENDING, clear the timeout counter.
    - A vsync edge in the same cycle is ignored.
  - PENDING, evaluated in priority order:
    - (a) A vsync edge, or the timeout counter at FRAME_TIMEOUT-1: go to APPLY. A step arriving in the same cycle is carried forward (see APPLY).
    - (b) Otherwise, a step: target += step (mod 4). If the new target equals rot_idx, return to IDLE (request cancelled, no switch_done).
    - (c) The timeout counter increments every PENDING cycle.
  - APPLY, one cycle:
    - rot_idx <= target; key_in_ctl <= 1 << target; switch_done=1 in the following cycle, aligned with the new outputs.
    - Then go to IDLE, or to PENDING with target = new rot_idx + carried step if a step was carried.
- Output timing:
  - switch_pending = 1 exactly while in PENDING (registered).
  - key_in_ctl and rot_idx change only via APPLY and are always one-hot and consistent.
- Latency: vsync edge at the synced stage → key_in_ctl updated 2 cycles later, at the same edge as switch_done=1.
- Wrap-around: rot_idx 3 + cw → 0; rot_idx 0 + ccw → 3.

Test Plan (DEBOUNCE_CYCLES=8, FRAME_TIMEOUT=100):
- Reset, hold key_cw_n low 20 cycles, then pulse vs_in high → exactly one switch_done; key_in_ctl 0001→0010, rot_idx=1; switch_pending high from press acceptance until the apply.
- key_cw_n low for 5 cycles only (bounce) → no press event; switch_pending stays 0; key_in_ctl=0001.
- From rot_idx=0, one ccw press with no vsync → after 100 PENDING cycles, timeout apply: rot_idx=3, key_in_ctl=1000.
- Press cw three times, then ccw once, all before vsync → target=2; on vsync, key_in_ctl=0100 with a single switch_done.
- Press cw then ccw before vsync → request cancelled: switch_pending returns to 0 and no switch_done on the next vsync.
- Assert sys_rst_n=0 while PENDING (target=2) → next cycle key_in_ctl=0001, switch_pending=0; a later vsync causes no switch.
- Both keys pressed simultaneously (debounced edges in the same cycle) → no step, no pending.
